// File: rtl/lsu_axil_bridge_if.sv
// AXI4-Lite bus (plus AxSIZE sideband) between the LSU bridge and the SoC
// interconnect.
//   master modport : bridge side (drives AW/W/AR payload and valids, B/R readies)
//   slave  modport : interconnect side
// Every channel uses plain AXI valid/ready semantics: a transfer happens on
// the rising clock edge where valid and ready are both high. The source holds
// valid and payload stable until that edge. Ready may depend on valid.
interface lsu_axil_bridge_if;
   logic        awvalid;
   logic        awready;
   logic [31:0] awaddr;
   logic [2:0]  awprot;
   logic [2:0]  awsize;
   logic        wvalid;
   logic        wready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        bvalid;
   logic        bready;
   logic [1:0]  bresp;
   logic        arvalid;
   logic        arready;
   logic [31:0] araddr;
   logic [2:0]  arprot;
   logic [2:0]  arsize;
   logic        rvalid;
   logic        rready;
   logic [31:0] rdata;
   logic [1:0]  rresp;

   modport master (
      output awvalid, awaddr, awprot, awsize, input awready,
      output wvalid, wdata, wstrb, input wready,
      input  bvalid, bresp, output bready,
      output arvalid, araddr, arprot, arsize, input arready,
      input  rvalid, rdata, rresp, output rready
   );

   modport slave (
      input  awvalid, awaddr, awprot, awsize, output awready,
      input  wvalid, wdata, wstrb, output wready,
      output bvalid, bresp, input bready,
      input  arvalid, araddr, arprot, arsize, output arready,
      output rvalid, rdata, rresp, input rready
   );
endinterface

// File: rtl/lsu_axil_bridge.sv
// lsu_axil_bridge: turns the LSU's single-outstanding request/response port
// into an AXI4-Lite master. One transaction is in flight at a time; write
// data, byte mask and read lanes pass through untouched.
//
// Ports:
//   clock, reset_n   clock and asynchronous active-low reset
//   io_reqValid      request valid (level; may linger one cycle after acceptance)
//   io_wen/io_addr/io_size/io_wdata/io_wmask   request fields
//   io_respValid     one-cycle completion pulse
//   io_rdata         raw read word (holds its value across writes)
//   dbg_state        current FSM state, for observation only
//   m_axi            AXI4-Lite master port (lsu_axil_bridge_if.master)
//
// Parameters:
//   PROT_VALUE  constant driven on AxPROT
//   RESP_REG    0: response taken straight from the R/B handshake
//               1: response registered, one extra cycle
//
// Optional feature, macro LSU_AXIL_BUS_ERROR_EN: adds io_err (flags a
// non-OKAY rresp/bresp alongside io_respValid) and err_addr (address of the
// most recent failing request, held until reset).
module lsu_axil_bridge #(
   parameter logic [2:0] PROT_VALUE = 3'b000,
   parameter bit         RESP_REG   = 1'b0
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              io_reqValid,
   input  logic              io_wen,
   input  logic [31:0]       io_addr,
   input  logic [1:0]        io_size,
   input  logic [31:0]       io_wdata,
   input  logic [3:0]        io_wmask,
   output logic              io_respValid,
   output logic [31:0]       io_rdata,
`ifdef LSU_AXIL_BUS_ERROR_EN
   output logic              io_err,
   output logic [31:0]       err_addr,
`endif
   output logic [2:0]        dbg_state,
   lsu_axil_bridge_if.master m_axi
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_ADDR = 3'd1,
      RD_DATA = 3'd2,
      WR_REQ  = 3'd3,
      WR_RESP = 3'd4,
      RESP    = 3'd5
   } state_t;

   state_t      state;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  wmask_q;
   logic        wen_q;
   logic [1:0]  size_q;
   logic [31:0] rdata_q;
   logic        aw_done;
   logic        w_done;
   logic        resp_q;
   logic        arvalid_q;
   logic        rready_q;
   logic        awvalid_q;
   logic        wvalid_q;
   logic        bready_q;

   logic r_fire, b_fire, aw_fire, w_fire;
   logic aw_done_n, w_done_n, resp_now;

   assign r_fire    = rready_q  & m_axi.rvalid;
   assign b_fire    = bready_q  & m_axi.bvalid;
   assign aw_fire   = awvalid_q & m_axi.awready;
   assign w_fire    = wvalid_q  & m_axi.wready;
   // Include the completing handshake so AW and W finishing together (or the
   // second one finishing) moves on to WR_RESP without an idle cycle.
   assign aw_done_n = aw_done | aw_fire;
   assign w_done_n  = w_done  | w_fire;
   assign resp_now  = wen_q ? b_fire : r_fire;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         wmask_q   <= '0;
         wen_q     <= 1'b0;
         size_q    <= '0;
         rdata_q   <= '0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         resp_q    <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (io_reqValid) begin
                  addr_q  <= io_addr;
                  wdata_q <= io_wdata;
                  wmask_q <= io_wmask;
                  wen_q   <= io_wen;
                  // Size 11 has no AXI-Lite meaning here; treat it as a word.
                  size_q  <= (io_size == 2'b11) ? 2'b10 : io_size;
                  if (io_wen) begin
                     aw_done   <= 1'b0;
                     w_done    <= 1'b0;
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     state     <= WR_REQ;
                  end else begin
                     arvalid_q <= 1'b1;
                     state     <= RD_ADDR;
                  end
               end
            end
            RD_ADDR: begin
               if (m_axi.arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state     <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (m_axi.rvalid) begin
                  rready_q <= 1'b0;
                  rdata_q  <= m_axi.rdata;
                  if (RESP_REG) begin
                     resp_q <= 1'b1;
                     state  <= RESP;
                  end else begin
                     state  <= IDLE;
                  end
               end
            end
            WR_REQ: begin
               aw_done <= aw_done_n;
               w_done  <= w_done_n;
               if (aw_fire) awvalid_q <= 1'b0;
               if (w_fire)  wvalid_q  <= 1'b0;
               if (aw_done_n && w_done_n) begin
                  bready_q <= 1'b1;
                  state    <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (m_axi.bvalid) begin
                  bready_q <= 1'b0;
                  if (RESP_REG) begin
                     resp_q <= 1'b1;
                     state  <= RESP;
                  end else begin
                     state  <= IDLE;
                  end
               end
            end
            RESP: begin
               resp_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign io_respValid = RESP_REG ? resp_q : resp_now;
   // Unregistered variant forwards the bus word in the R handshake cycle;
   // otherwise (and during writes) the last captured word is held.
   assign io_rdata     = (!RESP_REG && r_fire) ? m_axi.rdata : rdata_q;
   assign dbg_state    = state;

   assign m_axi.awvalid = awvalid_q;
   assign m_axi.awaddr  = addr_q;
   assign m_axi.awprot  = PROT_VALUE;
   assign m_axi.awsize  = {1'b0, size_q};
   assign m_axi.wvalid  = wvalid_q;
   assign m_axi.wdata   = wdata_q;
   assign m_axi.wstrb   = wmask_q;
   assign m_axi.bready  = bready_q;
   assign m_axi.arvalid = arvalid_q;
   assign m_axi.araddr  = addr_q;
   assign m_axi.arprot  = PROT_VALUE;
   assign m_axi.arsize  = {1'b0, size_q};
   assign m_axi.rready  = rready_q;

`ifdef LSU_AXIL_BUS_ERROR_EN
   logic err_now;
   logic err_q;

   assign err_now = (r_fire && (m_axi.rresp != 2'b00)) ||
                    (b_fire && (m_axi.bresp != 2'b00));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         err_q    <= 1'b0;
         err_addr <= '0;
      end else begin
         if (r_fire || b_fire) err_q    <= err_now;
         if (err_now)          err_addr <= addr_q;
      end
   end

   assign io_err = RESP_REG ? (resp_q & err_q) : err_now;
`else
   // Response codes are deliberately ignored in this build.
   logic unused_resp;
   assign unused_resp = ^{m_axi.rresp, m_axi.bresp};
`endif

endmodule

// File: tb/tb_lsu_axil_bridge.sv
// Bench for lsu_axil_bridge: a RESP_REG=0 instance (u_dut0) driven by a
// configurable-wait slave model and a RESP_REG=1 instance (u_dut1) with a
// zero-wait slave. Expected read words are queued when a request is driven
// and popped when io_respValid appears.
module tb_lsu_axil_bridge;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // ---------------- DUT0 (RESP_REG = 0) ----------------
   logic        io_reqValid, io_wen, io_respValid;
   logic [31:0] io_addr, io_wdata, io_rdata;
   logic [1:0]  io_size;
   logic [3:0]  io_wmask;
   logic [2:0]  d0_state;
`ifdef LSU_AXIL_BUS_ERROR_EN
   logic        io_err;
   logic [31:0] err_addr;
`endif
   lsu_axil_bridge_if m0 ();

   lsu_axil_bridge u_dut0 (
      .clock        (clock),
      .reset_n      (reset_n),
      .io_reqValid  (io_reqValid),
      .io_wen       (io_wen),
      .io_addr      (io_addr),
      .io_size      (io_size),
      .io_wdata     (io_wdata),
      .io_wmask     (io_wmask),
      .io_respValid (io_respValid),
      .io_rdata     (io_rdata),
`ifdef LSU_AXIL_BUS_ERROR_EN
      .io_err       (io_err),
      .err_addr     (err_addr),
`endif
      .dbg_state    (d0_state),
      .m_axi        (m0.master)
   );

   // ---------------- DUT1 (RESP_REG = 1) ----------------
   logic        r1_reqValid, r1_wen, r1_respValid;
   logic [31:0] r1_addr, r1_rdata, r1_data;
   logic [1:0]  r1_resp;
   logic [2:0]  d1_state;
`ifdef LSU_AXIL_BUS_ERROR_EN
   logic        r1_err;
   logic [31:0] r1_err_addr;
`endif
   lsu_axil_bridge_if m1 ();

   lsu_axil_bridge #(.PROT_VALUE(3'b000), .RESP_REG(1'b1)) u_dut1 (
      .clock        (clock),
      .reset_n      (reset_n),
      .io_reqValid  (r1_reqValid),
      .io_wen       (r1_wen),
      .io_addr      (r1_addr),
      .io_size      (2'b10),
      .io_wdata     (32'h0BAD_F00D),
      .io_wmask     (4'hF),
      .io_respValid (r1_respValid),
      .io_rdata     (r1_rdata),
`ifdef LSU_AXIL_BUS_ERROR_EN
      .io_err       (r1_err),
      .err_addr     (r1_err_addr),
`endif
      .dbg_state    (d1_state),
      .m_axi        (m1.master)
   );

   // ---------------- slave model + monitor ----------------
   int ar_wait = 0, aw_wait = 0, w_wait = 0, r_wait = 0, b_wait = 0;
   int ar_c = 0, aw_c = 0, w_c = 0, r_c = 0, b_c = 0;
   logic [31:0] s_rdata = '0;
   logic [31:0] r_lat = '0;
   logic [1:0]  s_rresp = 2'b00;

   int ar_n = 0, aw_n = 0, w_n = 0, resp_n = 0, resp_cyc = 0;
   int aw_hs_cyc = 0, w_hs_cyc = 0;
   logic [31:0] ar_addr, aw_addr, w_data;
   logic [2:0]  ar_size, aw_size, ar_prot, aw_prot;
   logic [3:0]  w_strb;
   logic        err0_last = 1'b0;

   int resp1_n = 0, resp1_cyc = 0;
   logic [31:0] resp1_rdata;
   logic        resp1_err = 1'b0;

   logic [31:0] exp_q[$];
   logic [31:0] model_rdata = '0;
   int acc_cyc = 0;
   int acc1 = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Slave outputs are driven at the falling edge, so they are stable for the
   // next rising edge; everything is sampled 1 time unit later.
   always @(negedge clock) begin
      if (!reset_n) begin
         m0.arready = 0; m0.awready = 0; m0.wready = 0;
         m0.rvalid = 0; m0.rdata = '0; m0.rresp = 2'b00;
         m0.bvalid = 0; m0.bresp = 2'b00;
         ar_c = 0; aw_c = 0; w_c = 0; r_c = 0; b_c = 0;
      end else begin
         m0.arready = m0.arvalid && (ar_c >= ar_wait);
         if (m0.arvalid) ar_c = m0.arready ? 0 : ar_c + 1;
         m0.awready = m0.awvalid && (aw_c >= aw_wait);
         if (m0.awvalid) aw_c = m0.awready ? 0 : aw_c + 1;
         m0.wready = m0.wvalid && (w_c >= w_wait);
         if (m0.wvalid) w_c = m0.wready ? 0 : w_c + 1;
         m0.rvalid = m0.rready && (r_c >= r_wait);
         m0.rdata  = m0.rvalid ? r_lat : 32'h0;
         m0.rresp  = m0.rvalid ? s_rresp : 2'b00;
         if (m0.rready) r_c = m0.rvalid ? 0 : r_c + 1;
         m0.bvalid = m0.bready && (b_c >= b_wait);
         m0.bresp  = 2'b00;
         if (m0.bready) b_c = m0.bvalid ? 0 : b_c + 1;
      end
      m1.arready = m1.arvalid;
      m1.rvalid  = m1.rready;
      m1.rdata   = m1.rvalid ? r1_data : 32'h0;
      m1.rresp   = m1.rvalid ? r1_resp : 2'b00;
      m1.awready = m1.awvalid;
      m1.wready  = m1.wvalid;
      m1.bvalid  = m1.bready;
      m1.bresp   = 2'b00;
      #1;
      if (m0.arvalid && m0.arready) begin
         ar_n++; ar_addr = m0.araddr; ar_size = m0.arsize; ar_prot = m0.arprot;
         r_lat = s_rdata;
      end
      if (m0.awvalid && m0.awready) begin
         aw_n++; aw_addr = m0.awaddr; aw_size = m0.awsize; aw_prot = m0.awprot;
         aw_hs_cyc = cyc;
      end
      if (m0.wvalid && m0.wready) begin
         w_n++; w_data = m0.wdata; w_strb = m0.wstrb; w_hs_cyc = cyc;
      end
      if (io_respValid === 1'b1) begin
         resp_n++; resp_cyc = cyc;
`ifdef LSU_AXIL_BUS_ERROR_EN
         err0_last = io_err;
`endif
         if (exp_q.size() == 0) check("unexpected_resp", 32'd1, 32'd0);
         else check("sb_rdata", io_rdata, exp_q.pop_front());
      end
      if (r1_respValid === 1'b1) begin
         resp1_n++; resp1_cyc = cyc; resp1_rdata = r1_rdata;
`ifdef LSU_AXIL_BUS_ERROR_EN
         resp1_err = r1_err;
`endif
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_req(input logic wen, input logic [31:0] addr, input logic [1:0] size,
                           input logic [31:0] wdata, input logic [3:0] wmask,
                           input logic [31:0] rdata, input int hold);
      @(posedge clock); #1;
      io_reqValid = 1'b1; io_wen = wen; io_addr = addr; io_size = size;
      io_wdata = wdata; io_wmask = wmask; s_rdata = rdata; acc_cyc = cyc;
      if (wen) exp_q.push_back(model_rdata);
      else begin exp_q.push_back(rdata); model_rdata = rdata; end
      repeat (hold) @(posedge clock);
      #1;
      io_reqValid = 1'b0;
   endtask

   task automatic wait_resp(input int target, input string name);
      int n;
      n = 0;
      while (resp_n < target && n < 60) begin
         @(negedge clock); #2; n++;
      end
      check({name, "_timeout"}, 32'(resp_n >= target), 32'd1);
   endtask

   task automatic send1(input logic wen, input logic [31:0] addr, input logic [31:0] data,
                        input logic [1:0] resp);
      int n;
      int start;
      @(posedge clock); #1;
      r1_reqValid = 1'b1; r1_wen = wen; r1_addr = addr; r1_data = data; r1_resp = resp;
      acc1 = cyc; start = resp1_n;
      @(posedge clock); #1;
      r1_reqValid = 1'b0;
      n = 0;
      while (resp1_n == start && n < 40) begin
         @(negedge clock); #2; n++;
      end
      check("r1_timeout", 32'(resp1_n > start), 32'd1);
      check("r1_latency", 32'(resp1_cyc - acc1), 32'd3);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        wen;
      logic [31:0] addr;
      logic [1:0]  size;
      logic [31:0] wdata;
      logic [3:0]  wmask;
      logic [31:0] rdata;
      logic [2:0]  exp_size;
   } vec_t;

   localparam int NV = 8;
   vec_t vecs[NV];

   int ar0, aw0, w0, r0;
   logic [31:0] first_addr;

   initial begin
      vecs[0] = '{1'b0, 32'h8000_0010, 2'b10, 32'h0, 4'h0, 32'hDEAD_BEEF, 3'b010};
      vecs[1] = '{1'b0, 32'h0000_0003, 2'b00, 32'h0, 4'h0, 32'h0000_00A5, 3'b000};
      vecs[2] = '{1'b0, 32'h0000_0102, 2'b01, 32'h0, 4'h0, 32'hCAFE_0000, 3'b001};
      vecs[3] = '{1'b0, 32'h0000_0004, 2'b11, 32'h0, 4'h0, 32'h1234_5678, 3'b010};
      vecs[4] = '{1'b1, 32'h0000_0020, 2'b10, 32'h1122_3344, 4'b1111, 32'h0, 3'b010};
      vecs[5] = '{1'b1, 32'h0000_0021, 2'b00, 32'h0000_AA00, 4'b0010, 32'h0, 3'b000};
      vecs[6] = '{1'b1, 32'h0000_0022, 2'b01, 32'hBEEF_0000, 4'b1100, 32'h0, 3'b001};
      vecs[7] = '{1'b1, 32'h0000_0030, 2'b11, 32'hFFFF_0001, 4'b1111, 32'h0, 3'b010};

      io_reqValid = 0; io_wen = 0; io_addr = '0; io_size = '0; io_wdata = '0; io_wmask = '0;
      r1_reqValid = 0; r1_wen = 0; r1_addr = '0; r1_data = '0; r1_resp = 2'b00;

      // ---- reset state ----
      reset_n = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_state", 32'(d0_state), 32'd0);
      check("rst_valids", 32'({m0.arvalid, m0.awvalid, m0.wvalid, m0.bready, m0.rready, io_respValid}), 32'd0);
      check("rst_rdata", io_rdata, 32'h0);
      check("rst_araddr", m0.araddr, 32'h0);
      check("rst_r1_valid", 32'(r1_respValid), 32'd0);
      reset_n = 1'b1;

      // ---- table: zero-wait slave, all sizes, reads and writes ----
      for (int i = 0; i < NV; i++) begin
         ar0 = ar_n; aw0 = aw_n; w0 = w_n; r0 = resp_n;
         send_req(vecs[i].wen, vecs[i].addr, vecs[i].size, vecs[i].wdata,
                  vecs[i].wmask, vecs[i].rdata, 1);
         wait_resp(r0 + 1, "vec");
         check("vec_latency", 32'(resp_cyc - acc_cyc), 32'd2);
         if (vecs[i].wen) begin
            check("vec_aw_count", 32'(aw_n), 32'(aw0 + 1));
            check("vec_w_count", 32'(w_n), 32'(w0 + 1));
            check("vec_awaddr", aw_addr, vecs[i].addr);
            check("vec_awsize", 32'(aw_size), 32'(vecs[i].exp_size));
            check("vec_awprot", 32'(aw_prot), 32'd0);
            check("vec_wdata", w_data, vecs[i].wdata);
            check("vec_wstrb", 32'(w_strb), 32'(vecs[i].wmask));
         end else begin
            check("vec_ar_count", 32'(ar_n), 32'(ar0 + 1));
            check("vec_araddr", ar_addr, vecs[i].addr);
            check("vec_arsize", 32'(ar_size), 32'(vecs[i].exp_size));
            check("vec_arprot", 32'(ar_prot), 32'd0);
         end
      end

      // ---- write, W accepted at cycle 1, AW at cycle 4, B at cycle 6 ----
      aw_wait = 3; w_wait = 0; b_wait = 1;
      aw0 = aw_n; w0 = w_n; r0 = resp_n;
      send_req(1'b1, 32'h0000_0040, 2'b10, 32'h1122_3344, 4'b1100, 32'h0, 1);
      wait_resp(r0 + 1, "wfirst");
      check("wfirst_latency", 32'(resp_cyc - acc_cyc), 32'd6);
      check("wfirst_w_cycle", 32'(w_hs_cyc - acc_cyc), 32'd1);
      check("wfirst_aw_cycle", 32'(aw_hs_cyc - acc_cyc), 32'd4);
      check("wfirst_aw_count", 32'(aw_n), 32'(aw0 + 1));
      check("wfirst_w_count", 32'(w_n), 32'(w0 + 1));
      check("wfirst_wstrb", 32'(w_strb), 32'b1100);
      aw_wait = 0; b_wait = 0;

      // ---- extended io_reqValid, then back-to-back request in response cycle ----
      ar0 = ar_n; r0 = resp_n;
      send_req(1'b0, 32'h0000_0100, 2'b10, 32'h0, 4'h0, 32'h0A0B_0C0D, 2);
      io_reqValid = 1'b1; io_addr = 32'h0000_0104;
      s_rdata = 32'h0102_0304;
      exp_q.push_back(32'h0102_0304); model_rdata = 32'h0102_0304;
      @(posedge clock); #1;
      acc_cyc = cyc;
      @(posedge clock); #1;
      io_reqValid = 1'b0;
      wait_resp(r0 + 2, "b2b");
      check("b2b_latency", 32'(resp_cyc - acc_cyc), 32'd2);
      repeat (4) @(negedge clock);
      #2;
      check("b2b_ar_count", 32'(ar_n), 32'(ar0 + 2));
      check("b2b_araddr", ar_addr, 32'h0000_0104);
      check("b2b_resp_count", 32'(resp_n), 32'(r0 + 2));

      // ---- arready stalled 5 cycles while io_addr wanders ----
      ar_wait = 5;
      ar0 = ar_n; r0 = resp_n;
      send_req(1'b0, 32'h0000_0200, 2'b10, 32'h0, 4'h0, 32'h7777_8888, 1);
      for (int k = 0; k < 5; k++) begin
         io_addr = 32'($urandom_range(0, 32'h0FFF_FFFF));
         @(negedge clock); #2;
         check("stall_arvalid", 32'(m0.arvalid), 32'd1);
         check("stall_araddr", m0.araddr, 32'h0000_0200);
      end
      wait_resp(r0 + 1, "stall");
      check("stall_latency", 32'(resp_cyc - acc_cyc), 32'd7);
      ar_wait = 0;
      repeat (3) @(negedge clock);
      #2;
      check("stall_single_resp", 32'(resp_n), 32'(r0 + 1));
      check("stall_ar_count", 32'(ar_n), 32'(ar0 + 1));

      // ---- random mix with random wait states ----
      for (int i = 0; i < 6; i++) begin
         ar_wait = $urandom_range(0, 3); aw_wait = $urandom_range(0, 3);
         w_wait = $urandom_range(0, 3); r_wait = $urandom_range(0, 3);
         b_wait = $urandom_range(0, 3);
         r0 = resp_n;
         send_req(1'($urandom_range(0, 1)), 32'($urandom_range(0, 1023)) << 2, 2'b10,
                  32'($urandom), 4'($urandom_range(0, 15)), 32'($urandom), 1);
         wait_resp(r0 + 1, "rand");
         check("rand_latency_min", 32'((resp_cyc - acc_cyc) >= 2), 32'd1);
      end
      ar_wait = 0; aw_wait = 0; w_wait = 0; r_wait = 0; b_wait = 0;

      // ---- reset while waiting in WR_RESP ----
      b_wait = 20;
      send_req(1'b1, 32'h0000_0050, 2'b10, 32'hA5A5_A5A5, 4'hF, 32'h0, 1);
      @(posedge clock); #1;
      check("wr_resp_reached", 32'(d0_state), 32'd4);
      reset_n = 1'b0;
      #1;
      check("midrst_valids", 32'({m0.arvalid, m0.awvalid, m0.wvalid, m0.bready, m0.rready, io_respValid}), 32'd0);
      check("midrst_state", 32'(d0_state), 32'd0);
      check("midrst_rdata", io_rdata, 32'h0);
      exp_q.delete();
      model_rdata = '0;
      b_wait = 0;
      @(posedge clock); #1;
      reset_n = 1'b1;
      r0 = resp_n;
      send_req(1'b0, 32'h0000_0060, 2'b10, 32'h0, 4'h0, 32'h0000_0077, 1);
      wait_resp(r0 + 1, "postrst");
      check("postrst_latency", 32'(resp_cyc - acc_cyc), 32'd2);
      check("postrst_araddr", ar_addr, 32'h0000_0060);

`ifdef LSU_AXIL_BUS_ERROR_EN
      // ---- error response on the unregistered instance ----
      s_rresp = 2'b11;
      r0 = resp_n;
      send_req(1'b0, 32'h0000_0070, 2'b10, 32'h0, 4'h0, 32'h0000_0099, 1);
      wait_resp(r0 + 1, "err0");
      check("err0_flag", 32'(err0_last), 32'd1);
      s_rresp = 2'b00;
      @(posedge clock); #1;
      check("err0_addr", err_addr, 32'h0000_0070);
`endif

      // ---- registered-response instance ----
      send1(1'b0, 32'h0000_0020, 32'h55AA_55AA, 2'b10);
      check("r1_rdata", resp1_rdata, 32'h55AA_55AA);
`ifdef LSU_AXIL_BUS_ERROR_EN
      check("r1_err", 32'(resp1_err), 32'd1);
      check("r1_err_addr", r1_err_addr, 32'h0000_0020);
`endif
      send1(1'b1, 32'h0000_0024, 32'h0, 2'b00);
      check("r1_wr_rdata_hold", resp1_rdata, 32'h55AA_55AA);
`ifdef LSU_AXIL_BUS_ERROR_EN
      check("r1_ok_err", 32'(resp1_err), 32'd0);
      check("r1_err_addr_hold", r1_err_addr, 32'h0000_0020);
`endif

      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      errors++;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
